// File: rtl/board_caps_regbank.sv
// Bank of board-capability registers on the ZX-UNO register interface, with boot-mode
// write protection and a key-sequence unlock that grants one protected write outside boot.
module board_caps_regbank #(
  parameter int unsigned       NREGS          = 4,
  parameter logic [7:0]        BASE_ADDR      = 8'hF0,
  parameter int unsigned       WIDTH          = 2,
  parameter logic [NREGS*WIDTH-1:0] RESET_VALUES = '0,
  parameter logic [NREGS-1:0]  BOOT_MASK      = '1,
  parameter logic [7:0]        KEY0           = 8'hA5,
  parameter logic [7:0]        KEY1           = 8'h5A,
  parameter logic [15:0]       UNLOCK_TIMEOUT = 16'd65535
) (
  input  logic                   clk,
  input  logic                   poweron_rst_n,
  input  logic                   in_boot_mode,
  input  logic [7:0]             zxuno_addr,
  input  logic                   zxuno_regrd,
  input  logic                   zxuno_regwr,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   oe_n,
  output logic [NREGS*WIDTH-1:0] current_value,
  output logic [NREGS-1:0]       changed,
  output logic                   unlocked
);

  localparam logic [7:0] CtrlAddr = BASE_ADDR + 8'(NREGS);

  typedef enum logic [1:0] {StLocked, StKey0Seen, StUnlocked} state_e;

  state_e                   state_q;
  logic [15:0]              cnt_q;
  logic                     regwr_q;
  logic [NREGS*WIDTH-1:0]   regs_q;
  logic [NREGS-1:0]         changed_q;

  logic [NREGS-1:0]         sel;
  logic [NREGS-1:0]         accept;
  logic                     ctrl_sel;
  logic                     wr_ev;
  logic                     ctrl_wr;
  logic                     data_wr;
  logic                     consume;

  for (genvar g = 0; g < NREGS; g++) begin : g_sel
    assign sel[g]    = (zxuno_addr == BASE_ADDR + 8'(g));
    assign accept[g] = wr_ev && sel[g] &&
                       (!BOOT_MASK[g] || in_boot_mode || state_q == StUnlocked);
  end

  assign ctrl_sel = (zxuno_addr == CtrlAddr);
  // One write event per strobe: only the rising edge of the level strobe counts.
  assign wr_ev    = zxuno_regwr && !regwr_q;
  assign ctrl_wr  = wr_ev && ctrl_sel;
  assign data_wr  = wr_ev && (|sel);
  assign consume  = (|(accept & BOOT_MASK)) && !in_boot_mode;

  always_ff @(posedge clk or negedge poweron_rst_n) begin
    if (!poweron_rst_n) begin
      regwr_q   <= 1'b0;
      regs_q    <= RESET_VALUES;
      changed_q <= '0;
    end else begin
      regwr_q <= zxuno_regwr;
      for (int i = 0; i < NREGS; i++) begin
        changed_q[i] <= accept[i] && (din[WIDTH-1:0] != regs_q[i*WIDTH +: WIDTH]);
        if (accept[i]) regs_q[i*WIDTH +: WIDTH] <= din[WIDTH-1:0];
      end
    end
  end

  // Control writes win over one-shot consumption, which wins over the timeout.
  always_ff @(posedge clk or negedge poweron_rst_n) begin
    if (!poweron_rst_n) begin
      state_q <= StLocked;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StLocked: begin
          if (ctrl_wr && din == KEY0) state_q <= StKey0Seen;
        end
        StKey0Seen: begin
          if (ctrl_wr) begin
            if (din == KEY1) begin
              state_q <= StUnlocked;
              cnt_q   <= UNLOCK_TIMEOUT - 16'd1;
            end else if (din != KEY0) begin
              state_q <= StLocked;
            end
          end else if (data_wr) begin
            state_q <= StLocked;
          end
        end
        StUnlocked: begin
          if (ctrl_wr) begin
            state_q <= (din == KEY0) ? StKey0Seen : StLocked;
          end else if (consume || cnt_q == 16'd0) begin
            state_q <= StLocked;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= StLocked;
      endcase
    end
  end

  always_comb begin
    dout = 8'h00;
    oe_n = 1'b1;
    if (zxuno_regrd) begin
      for (int i = 0; i < NREGS; i++) begin
        if (sel[i]) begin
          oe_n              = 1'b0;
          dout[WIDTH-1:0]   = regs_q[i*WIDTH +: WIDTH];
        end
      end
      if (ctrl_sel) begin
        oe_n = 1'b0;
        dout = {5'b0, in_boot_mode, state_q == StUnlocked, state_q == StKey0Seen};
      end
    end
  end

  assign current_value = regs_q;
  assign changed       = changed_q;
  assign unlocked      = (state_q == StUnlocked);

endmodule

// File: tb/tb_board_caps_regbank.sv
// Directed self-checking bench for board_caps_regbank (4 x 2-bit regs, short unlock timeout).
module tb_board_caps_regbank;

  logic       clk = 1'b0;
  logic       poweron_rst_n = 1'b0;
  logic       in_boot_mode = 1'b0;
  logic [7:0] zxuno_addr = 8'h00;
  logic       zxuno_regrd = 1'b0;
  logic       zxuno_regwr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe_n;
  logic [7:0] current_value;
  logic [3:0] changed;
  logic       unlocked;

  int total = 0;
  int bad   = 0;
  logic [3:0] chg;
  logic [7:0] rd_data;
  logic       rd_oe_n;

  board_caps_regbank #(
    .NREGS         (4),
    .BASE_ADDR     (8'hF0),
    .WIDTH         (2),
    .RESET_VALUES  (8'b11_10_01_00),
    .BOOT_MASK     (4'b1111),
    .KEY0          (8'hA5),
    .KEY1          (8'h5A),
    .UNLOCK_TIMEOUT(16'd4)
  ) dut (
    .clk          (clk),
    .poweron_rst_n(poweron_rst_n),
    .in_boot_mode (in_boot_mode),
    .zxuno_addr   (zxuno_addr),
    .zxuno_regrd  (zxuno_regrd),
    .zxuno_regwr  (zxuno_regwr),
    .din          (din),
    .dout         (dout),
    .oe_n         (oe_n),
    .current_value(current_value),
    .changed      (changed),
    .unlocked     (unlocked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe then one idle cycle; chg holds changed seen just after the write edge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    zxuno_addr  = a;
    din         = d;
    zxuno_regwr = 1'b1;
    @(posedge clk);
    #1;
    chg         = changed;
    zxuno_regwr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a);
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    #1;
    rd_data     = dout;
    rd_oe_n     = oe_n;
    zxuno_regrd = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_cv", 32'(current_value), 32'hE4);
    check("rst_unl", 32'(unlocked), 32'h0);
    check("rst_chg", 32'(changed), 32'h0);
    rd(8'hF2);
    check("rd_reg2", 32'(rd_data), 32'h02);
    check("rd_reg2_oe", 32'(rd_oe_n), 32'h0);
    poweron_rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(8'hF4);
    check("rd_stat0", 32'(rd_data), 32'h00);
    rd(8'hF8);
    check("rd_oor_oe", 32'(rd_oe_n), 32'h1);
    check("rd_oor_d", 32'(rd_data), 32'h00);

    // Boot-mode write held 5 cycles: exactly one event, one changed pulse
    in_boot_mode = 1'b1;
    zxuno_addr   = 8'hF0;
    din          = 8'h03;
    zxuno_regwr  = 1'b1;
    @(posedge clk);
    #1;
    check("boot_cv", 32'(current_value), 32'hE7);
    check("boot_chg", 32'(changed), 32'h1);
    @(posedge clk);
    #1;
    check("boot_chg_once", 32'(changed), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    zxuno_regwr = 1'b0;
    @(posedge clk);
    #1;
    rd(8'hF4);
    check("rd_stat_boot", 32'(rd_data), 32'h04);
    in_boot_mode = 1'b0;
    wr(8'hF0, 8'h01);
    check("prot_rej_cv", 32'(current_value), 32'hE7);
    check("prot_rej_chg", 32'(chg), 32'h0);

    // Unlock and one-shot consumption
    wr(8'hF4, 8'hA5);
    rd(8'hF4);
    check("stat_key0", 32'(rd_data), 32'h01);
    wr(8'hF4, 8'h5A);
    rd(8'hF4);
    check("stat_unl", 32'(rd_data), 32'h02);
    check("unl_out", 32'(unlocked), 32'h1);
    wr(8'hF0, 8'h01);
    check("oneshot_cv", 32'(current_value), 32'hE5);
    check("oneshot_chg", 32'(chg), 32'h1);
    check("oneshot_lock", 32'(unlocked), 32'h0);
    wr(8'hF0, 8'h02);
    check("oneshot_rej", 32'(current_value), 32'hE5);

    // A data write between keys breaks the sequence
    wr(8'hF4, 8'hA5);
    wr(8'hF1, 8'h00);
    rd(8'hF4);
    check("seq_break_stat", 32'(rd_data), 32'h00);
    check("seq_break_cv", 32'(current_value), 32'hE5);
    wr(8'hF4, 8'h5A);
    rd(8'hF4);
    check("seq_break_key1", 32'(rd_data), 32'h00);

    // Timeout of 4 cycles; write on last unlocked edge is accepted
    wr(8'hF4, 8'hA5);
    wr(8'hF4, 8'h5A);
    repeat (2) @(posedge clk);
    #1;
    check("to_still_unl", 32'(unlocked), 32'h1);
    @(posedge clk);
    #1;
    check("to_expired", 32'(unlocked), 32'h0);

    wr(8'hF4, 8'hA5);
    wr(8'hF4, 8'h5A);
    repeat (2) @(posedge clk);
    #1;
    wr(8'hF2, 8'h01);
    check("to_last_cv", 32'(current_value), 32'hD5);
    check("to_last_chg", 32'(chg), 32'h4);
    check("to_last_lock", 32'(unlocked), 32'h0);

    // Reset mid-unlock with strobe held, then one event after release
    wr(8'hF4, 8'hA5);
    wr(8'hF4, 8'h5A);
    check("pre_rst_unl", 32'(unlocked), 32'h1);
    zxuno_addr  = 8'hF2;
    din         = 8'h03;
    zxuno_regwr = 1'b1;
    #2;
    poweron_rst_n = 1'b0;
    #1;
    check("midrst_cv", 32'(current_value), 32'hE4);
    check("midrst_unl", 32'(unlocked), 32'h0);
    in_boot_mode = 1'b1;
    zxuno_addr   = 8'hF1;
    din          = 8'h00;
    repeat (2) @(posedge clk);
    #3;
    poweron_rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_cv", 32'(current_value), 32'hE0);
    check("post_rst_chg", 32'(changed), 32'h2);
    din = 8'h02;
    @(posedge clk);
    #1;
    check("post_rst_once", 32'(current_value), 32'hE0);
    check("post_rst_chg0", 32'(changed), 32'h0);
    zxuno_regwr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_caps_regbank.md
# board_caps_regbank

Parametrised bank of board-capability/configuration registers on the ZX-UNO register interface. It generalises the single boot-mode-only capability register into NREGS registers of WIDTH bits at consecutive ZX-UNO addresses. Each register can be flagged as boot-protected. A key-sequence unlock FSM with timeout gives one-shot write access to protected registers outside boot mode. It sits beside the other ZX-UNO register decoders, and its outputs feed the memory/board configuration logic.

## Interface
- NREGS, 4: number of data registers (1..16); addresses BASE_ADDR .. BASE_ADDR+NREGS-1
- BASE_ADDR, 8'hF0: address of register 0; control/status register is at BASE_ADDR+NREGS; BASE_ADDR+NREGS must be ≤ 8'hFF
- WIDTH, 2: bits per register (1..8)
- RESET_VALUES, 0: NREGS*WIDTH flattened reset values; register i is [i*WIDTH +: WIDTH]
- BOOT_MASK, all ones: bit i=1 makes register i boot-protected
- KEY0, 8'hA5 / KEY1, 8'h5A: unlock sequence written to the control address
- UNLOCK_TIMEOUT, 16'd65535: cycles the UNLOCKED state lasts (≥1)
- clk  in  1  system clock
- poweron_rst_n  in  1  asynchronous active-low reset
- in_boot_mode  in  1  high while the boot ROM is running
- zxuno_addr  in  8  selected ZX-UNO register
- zxuno_regrd  in  1  read strobe (level)
- zxuno_regwr  in  1  write strobe (level; may span several cycles)
- din  in  8  write data
- dout  out  8  read data (combinational)
- oe_n  out  1  low when this block drives dout
- current_value  out  NREGS*WIDTH  live register contents, flattened
- changed  out  NREGS  one-cycle pulse per register whose value changed
- unlocked  out  1  high in UNLOCKED

## Operation
- Write event: one per strobe, on the clock edge where zxuno_regwr=1 and its registered copy regwr_q=0; regwr_q resets to 0. Write events to addresses outside BASE_ADDR..BASE_ADDR+NREGS are ignored entirely.
- Data write to register i is accepted if BOOT_MASK[i]=0, or in_boot_mode=1, or state=UNLOCKED (all evaluated before the edge). An accepted write loads reg[i] <= din[WIDTH-1:0]. A rejected write leaves reg[i] unchanged.
- changed[i] pulses high for the cycle after an accepted write whose value differs from the old reg[i].
- Read at a data address: oe_n=0 when zxuno_regrd=1; dout = zero-extended reg[i].
- Read at the control address: oe_n=0; dout = {5'b0, in_boot_mode, state==UNLOCKED, state==KEY0_SEEN}.
- With no read in range: oe_n=1, dout=8'h00.
- FSM states: LOCKED (reset), KEY0_SEEN, UNLOCKED.
  - LOCKED: control write of KEY0 → KEY0_SEEN. Any other event leaves the state at LOCKED.
  - KEY0_SEEN: control write of KEY1 → UNLOCKED, counter loaded with UNLOCK_TIMEOUT-1. Control write of KEY0 keeps KEY0_SEEN. Any other control write, or any data write event (accepted or not), → LOCKED.
  - UNLOCKED: counter decrements every cycle; when the counter is 0 → LOCKED. Control write of KEY0 → KEY0_SEEN; any other control write → LOCKED. An accepted write to a boot-protected register while in_boot_mode=0 → LOCKED (one-shot). Writes to unprotected registers, and writes made in boot mode, do not consume the unlock.
- Priority within one edge: control write decides first, then one-shot consumption, then timeout.
- A write on the edge where the counter reaches 0 is still accepted; the FSM goes to LOCKED on that edge.
- A change of in_boot_mode alone never changes the FSM state.

## Timing
- Reset (async assert, sync use of deassert): reg[i]=RESET_VALUES slice, state=LOCKED, counter=0, regwr_q=0, changed=0, unlocked=0. oe_n and dout follow the read decode immediately.
- Write latency: current_value, state and unlocked update on the first clock edge of the strobe and are visible the following cycle. changed is visible in that same following cycle, for one cycle.
- A strobe held N cycles produces exactly one write event. Deassert for at least one cycle before the next write.
- Read path is combinational, with zero latency.
- Reset asserted mid-unlock or mid-strobe returns all state to reset values at once. A strobe still high after reset release produces a write event on the first edge.

## Test plan
- Reset with RESET_VALUES=8'b11_10_01_00 → current_value=8'hE4, unlocked=0; read BASE_ADDR+2 → dout=8'h02, oe_n=0.
- in_boot_mode=1, write 8'h03 to BASE_ADDR held 5 cycles → reg0=3 after one edge, changed[0] pulses once. in_boot_mode=0, write 8'h01 → reg0 stays 3, changed stays 0.
- in_boot_mode=0: write A5 then 5A to the control address → status reads 8'h02. Write 1 to BASE_ADDR → accepted, state returns to LOCKED, a second write is rejected.
- Write A5, then a data write, then 5A → remains LOCKED, status reads 8'h00.
- UNLOCK_TIMEOUT=4: unlock, then wait 4 cycles → unlocked=0. A write on the last UNLOCKED edge is accepted.
- Assert poweron_rst_n=0 while UNLOCKED with regwr held high → immediate reset values. After release, exactly one write event occurs.
